// File: rtl/mtsp_scratch_pkg.sv
// Shared types and default constants for the MTSP scratch-memory responder.
package mtsp_scratch_pkg;

   localparam int DEF_ADDR_WIDTH = 10;
   localparam int DEF_GPR_WIDTH  = 6;
   localparam int DEF_FIFO_DEPTH = 4;
   localparam int DATA_WIDTH     = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      B0   = 2'd1,
      B1   = 2'd2
   } state_t;

   typedef struct packed {
      logic [DEF_GPR_WIDTH-1:0] dest;
      logic [DATA_WIDTH-1:0]    data;
   } rsp_beat_t;

endpackage

// File: rtl/mtsp_scratch_rsp_fifo.sv
// First-word-fall-through FIFO of response beats; srst flushes all entries.
module mtsp_scratch_rsp_fifo
   import mtsp_scratch_pkg::*;
#(
   parameter int  DEPTH  = DEF_FIFO_DEPTH,
   parameter type beat_t = rsp_beat_t
) (
   input  logic                    clk,
   input  logic                    srst,
   input  logic                    push,
   input  beat_t                   push_beat,
   input  logic                    pop,
   output beat_t                   head_beat,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int PW = $clog2(DEPTH);

   beat_t          mem [DEPTH];
   logic [PW-1:0]  wr_ptr_reg;
   logic [PW-1:0]  rd_ptr_reg;
   logic [PW:0]    count_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_reg + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg] <= push_beat;
   end

   assign head_beat = mem[rd_ptr_reg];
   assign count     = count_reg;

endmodule

// File: rtl/mtsp_scratch_mem.sv
// Two-beat scratch RAM responder with credit-based response FIFO.
// Optional MTSP_SCRATCH_OVERRUN_EN enables the sticky ERR_OVERRUN detector.
module mtsp_scratch_mem
   import mtsp_scratch_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int GPR_WIDTH  = DEF_GPR_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  MEM_nEN,
   input  logic                  MEM_WRITE,
   input  logic [15:0]           MEM_ADDR,
   input  logic [GPR_WIDTH-1:0]  MEM_SRC,
   input  logic [127:0]          MEM_DATA_0,
   input  logic [127:0]          MEM_DATA_1,
   output logic                  MEM_BUSY,
   output logic                  RSP_VALID,
   input  logic                  RSP_READY,
   output logic [GPR_WIDTH-1:0]  RSP_DEST,
   output logic [127:0]          RSP_DATA,
   output logic                  ERR_OVERRUN
);

   localparam int RW = $clog2(FIFO_DEPTH) + 2;

   typedef struct packed {
      logic [GPR_WIDTH-1:0]  dest;
      logic [DATA_WIDTH-1:0] data;
   } beat_t;

   state_t                 state_reg;
   logic                   write_reg;
   logic [ADDR_WIDTH-1:0]  addr_reg;
   logic [GPR_WIDTH-1:0]   src_reg;
   logic [127:0]           data0_reg;
   logic [127:0]           data1_reg;
   logic [RW-1:0]          reserved_reg;

   logic [127:0]           ram [2**ADDR_WIDTH];
   logic [127:0]           rd_data_reg;
   logic [GPR_WIDTH-1:0]   rd_dest_reg;
   logic                   rd_vld_reg;

   logic                   accept;
   logic                   in_beat;
   logic                   beat1;
   logic                   wr_en;
   logic                   rd_en;
   logic                   pop;
   logic [ADDR_WIDTH-1:0]  ram_idx;
   logic [RW-1:0]          res_add;
   logic [RW-1:0]          res_sub;
   beat_t                  push_beat;
   beat_t                  head_beat;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                   unused_addr_hi;

   assign unused_addr_hi = ^MEM_ADDR[15:ADDR_WIDTH];

   // Busy depends only on registered state so the core sees no combinational loop.
   assign MEM_BUSY = (state_reg == B0) || (reserved_reg > RW'(FIFO_DEPTH - 2));
   assign accept   = !MEM_nEN && !MEM_BUSY;

   assign in_beat  = (state_reg == B0) || (state_reg == B1);
   assign beat1    = (state_reg == B1);
   assign ram_idx  = addr_reg + {{(ADDR_WIDTH-1){1'b0}}, beat1};
   assign wr_en    = in_beat && write_reg && !RST;
   assign rd_en    = in_beat && !write_reg && !RST;

   assign pop      = RSP_VALID && RSP_READY;
   assign res_add  = (accept && !MEM_WRITE) ? RW'(2) : '0;
   assign res_sub  = pop ? RW'(1) : '0;

   always_ff @(posedge CLK) begin
      if (wr_en)
         ram[ram_idx] <= beat1 ? data1_reg : data0_reg;
      if (rd_en)
         rd_data_reg <= ram[ram_idx];
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg    <= IDLE;
         write_reg    <= 1'b0;
         addr_reg     <= '0;
         src_reg      <= '0;
         data0_reg    <= '0;
         data1_reg    <= '0;
         reserved_reg <= '0;
         rd_vld_reg   <= 1'b0;
         rd_dest_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE:    state_reg <= accept ? B0 : IDLE;
            B0:      state_reg <= B1;
            B1:      state_reg <= accept ? B0 : IDLE;
            default: state_reg <= IDLE;
         endcase
         if (accept) begin
            write_reg <= MEM_WRITE;
            addr_reg  <= MEM_ADDR[ADDR_WIDTH-1:0];
            src_reg   <= MEM_SRC;
            data0_reg <= MEM_DATA_0;
            data1_reg <= MEM_DATA_1;
         end
         rd_vld_reg   <= rd_en;
         rd_dest_reg  <= src_reg + {{(GPR_WIDTH-1){1'b0}}, beat1};
         reserved_reg <= reserved_reg + res_add - res_sub;
      end
   end

   assign push_beat = '{dest: rd_dest_reg, data: rd_data_reg};

   mtsp_scratch_rsp_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .beat_t (beat_t)
   ) u_rsp_fifo (
      .clk       (CLK),
      .srst      (RST),
      .push      (rd_vld_reg),
      .push_beat (push_beat),
      .pop       (pop),
      .head_beat (head_beat),
      .count     (fifo_count)
   );

   // Payload is forced to zero while empty so reset shows clean outputs.
   assign RSP_VALID = (fifo_count != '0);
   assign RSP_DEST  = RSP_VALID ? head_beat.dest : '0;
   assign RSP_DATA  = RSP_VALID ? head_beat.data : '0;

`ifdef MTSP_SCRATCH_OVERRUN_EN
   logic err_reg;

   always_ff @(posedge CLK) begin
      if (RST)
         err_reg <= 1'b0;
      else if (!MEM_nEN && MEM_BUSY)
         err_reg <= 1'b1;
   end

   assign ERR_OVERRUN = err_reg;
`else
   assign ERR_OVERRUN = 1'b0;
`endif

endmodule

// File: tb/tb_mtsp_scratch_mem.sv
// Self-checking bench for mtsp_scratch_mem: directed cases plus random traffic vs. a queue model.
module tb_mtsp_scratch_mem;

   localparam int DEPTH = 4;
`ifdef MTSP_SCRATCH_OVERRUN_EN
   localparam bit OVR_EN = 1'b1;
`else
   localparam bit OVR_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         mem_nen;
   logic         mem_write;
   logic [15:0]  mem_addr;
   logic [5:0]   mem_src;
   logic [127:0] mem_data_0;
   logic [127:0] mem_data_1;
   logic         mem_busy;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [5:0]   rsp_dest;
   logic [127:0] rsp_data;
   logic         err_overrun;

   always #5 clk = ~clk;

   mtsp_scratch_mem dut (
      .CLK         (clk),
      .RST         (rst),
      .MEM_nEN     (mem_nen),
      .MEM_WRITE   (mem_write),
      .MEM_ADDR    (mem_addr),
      .MEM_SRC     (mem_src),
      .MEM_DATA_0  (mem_data_0),
      .MEM_DATA_1  (mem_data_1),
      .MEM_BUSY    (mem_busy),
      .RSP_VALID   (rsp_valid),
      .RSP_READY   (rsp_ready),
      .RSP_DEST    (rsp_dest),
      .RSP_DATA    (rsp_data),
      .ERR_OVERRUN (err_overrun)
   );

   typedef struct {
      int           avail;
      logic [5:0]   dest;
      logic [127:0] data;
   } exp_t;

   // Behavioural model: memory image, pending beats with earliest-visible cycle, credits.
   logic [127:0] mdl_mem [1024];
   exp_t         mdl_q [$];
   int           mdl_credits;
   int           mdl_last_acc;
   logic         mdl_err;
   int           cyc;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 0;

   logic         s_busy, s_valid, s_err;
   logic [5:0]   s_dest;
   logic [127:0] s_data;

   localparam logic [127:0] H11 = {16{8'h11}};
   localparam logic [127:0] H22 = {16{8'h22}};
   localparam logic [127:0] HAA = {16{8'hAA}};
   localparam logic [127:0] HBB = {16{8'hBB}};

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   task automatic mdl_reset();
      mdl_q.delete();
      mdl_credits  = 0;
      mdl_last_acc = -10;
      mdl_err      = 1'b0;
   endtask

   // One clock cycle: drive, sample at negedge, compare against the model, advance the model.
   task automatic step(input logic r, input logic nen, input logic wr, input logic [15:0] addr,
                       input logic [5:0] src, input logic [127:0] d0, input logic [127:0] d1,
                       input logic rdy);
      logic       e_busy, e_valid, acc;
      logic [9:0] a, a1;
      @(posedge clk);
      #1;
      rst = r; mem_nen = nen; mem_write = wr; mem_addr = addr;
      mem_src = src; mem_data_0 = d0; mem_data_1 = d1; rsp_ready = rdy;
      @(negedge clk);
      s_busy = mem_busy; s_valid = rsp_valid; s_err = err_overrun;
      s_dest = rsp_dest; s_data = rsp_data;
      e_busy  = (mdl_last_acc == cyc - 1) || (mdl_credits > DEPTH - 2);
      e_valid = (mdl_q.size() > 0) && (mdl_q[0].avail <= cyc);
      if (chk_en) begin
         chk("busy", s_busy, e_busy);
         chk("valid", s_valid, e_valid);
         chk("err", s_err, mdl_err);
         if (e_valid) begin
            chk("dest", s_dest, mdl_q[0].dest);
            chk("data", s_data, mdl_q[0].data);
         end
      end
      if (r) begin
         mdl_reset();
      end else begin
         acc = !nen && !e_busy;
         if (!nen && e_busy && OVR_EN)
            mdl_err = 1'b1;
         if (e_valid && rdy) begin
            void'(mdl_q.pop_front());
            mdl_credits--;
         end
         if (acc) begin
            a  = addr[9:0];
            a1 = a + 10'd1;
            mdl_last_acc = cyc;
            if (wr) begin
               mdl_mem[a]  = d0;
               mdl_mem[a1] = d1;
            end else begin
               mdl_q.push_back('{cyc + 3, src, mdl_mem[a]});
               mdl_q.push_back('{cyc + 4, src + 6'd1, mdl_mem[a1]});
               mdl_credits += 2;
            end
         end
      end
      cyc++;
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++)
         step(1'b0, 1'b1, 1'b0, 16'h0, 6'h0, '0, '0, rdy);
   endtask

   task automatic rd(input logic [15:0] addr, input logic [5:0] src, input logic rdy);
      step(1'b0, 1'b0, 1'b0, addr, src, '0, '0, rdy);
   endtask

   task automatic wrt(input logic [15:0] addr, input logic [127:0] d0, input logic [127:0] d1);
      step(1'b0, 1'b0, 1'b1, addr, 6'h0, d0, d1, 1'b1);
   endtask

   initial begin
      int pops;
      cyc = 0;
      mdl_reset();
      step(1'b1, 1'b1, 1'b0, 16'h0, 6'h0, '0, '0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 16'h0, 6'h0, '0, '0, 1'b1);
      chk_en = 1;
      idle(1, 1'b1);
      chk("rst_busy", s_busy, 1'b0);
      chk("rst_valid", s_valid, 1'b0);
      chk("rst_dest", s_dest, 6'd0);
      chk("rst_data", s_data, 128'd0);
      chk("rst_err", s_err, 1'b0);

      // Fill the whole RAM so every later read has a known model value.
      for (int k = 0; k < 512; k++) begin
         wrt(16'(2 * k), {$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom});
         idle(1, 1'b1);
      end

      // Write then read back at index 5.
      wrt(16'h0005, H11, H22);
      idle(1, 1'b1);
      rd(16'h0005, 6'd8, 1'b1);
      idle(2, 1'b1);
      idle(1, 1'b1);
      chk("t1_b0_valid", s_valid, 1'b1);
      chk("t1_b0_dest", s_dest, 6'd8);
      chk("t1_b0_data", s_data, H11);
      idle(1, 1'b1);
      chk("t1_b1_dest", s_dest, 6'd9);
      chk("t1_b1_data", s_data, H22);

      // Address and destination wrap, plus upper-address aliasing.
      wrt(16'h03FF, HAA, HBB);
      idle(1, 1'b1);
      rd(16'hFFFF, 6'd63, 1'b1);
      idle(3, 1'b1);
      chk("t2_b0_dest", s_dest, 6'd63);
      chk("t2_b0_data", s_data, HAA);
      idle(1, 1'b1);
      chk("t2_b1_dest", s_dest, 6'd0);
      chk("t2_b1_data", s_data, HBB);
      rd(16'hFC05, 6'd1, 1'b1);
      idle(3, 1'b1);
      chk("t2_alias_data", s_data, H11);
      idle(2, 1'b1);

      // Back-to-back reads with a stalled response channel, then an overrun.
      rd(16'h0005, 6'd10, 1'b0);
      idle(1, 1'b0);
      chk("t3_busy_b0", s_busy, 1'b1);
      rd(16'h0005, 6'd20, 1'b0);
      chk("t3_second_ok", s_busy, 1'b0);
      idle(1, 1'b0);
      chk("t3_busy_credit", s_busy, 1'b1);
      rd(16'h0005, 6'd30, 1'b0);
      chk("t3_busy_ovr", s_busy, 1'b1);
      idle(1, 1'b0);
      chk("t3_err", s_err, OVR_EN);
      idle(2, 1'b0);
      chk("t3_hold_dest", s_dest, 6'd10);
      pops = 0;
      for (int i = 0; i < 8; i++) begin
         idle(1, 1'b1);
         if (s_valid) pops++;
      end
      chk("t3_beat_count", 32'(pops), 32'd4);

      // Ready toggling every cycle across two reads.
      rd(16'h0005, 6'd40, 1'b1);
      idle(1, 1'b0);
      rd(16'h0006, 6'd44, 1'b1);
      for (int i = 0; i < 12; i++)
         idle(1, logic'(i % 2));

      // Reset in the second beat cycle of a read.
      idle(2, 1'b1);
      rd(16'h0005, 6'd50, 1'b1);
      idle(1, 1'b1);
      step(1'b1, 1'b1, 1'b0, 16'h0, 6'h0, '0, '0, 1'b1);
      idle(1, 1'b1);
      chk("t5_valid", s_valid, 1'b0);
      chk("t5_busy", s_busy, 1'b0);
      chk("t5_err", s_err, 1'b0);
      idle(5, 1'b1);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         step(1'b0, ($urandom_range(0, 2) == 0), logic'($urandom_range(0, 1)),
              16'($urandom), 6'($urandom), {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, ($urandom_range(0, 3) != 0));
      end
      idle(12, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
